// File: rtl/param_fifo.sv
// ============================================================================
//  Module   : param_fifo
//  Purpose  : Single-clock parameterised FIFO with occupancy counter, level
//             flags, sticky overflow/underflow and optional show-ahead read.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module param_fifo #(
    parameter int Width            = 8,
    parameter int Depth            = 8,
    parameter int AlmostFullLevel  = Depth - 2,
    parameter int AlmostEmptyLevel = 2,
    parameter int ShowAhead        = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [Width-1:0]         cData,
    input  logic                     cPush,
    input  logic                     cPop,
    input  logic                     cClearErr,
    output logic [Width-1:0]         hData,
    output logic                     hFull,
    output logic                     hEmpty,
    output logic                     hAlmostFull,
    output logic                     hAlmostEmpty,
    output logic [$clog2(Depth):0]   hCount,
    output logic                     hOverflow,
    output logic                     hUnderflow
);

    localparam int                 c_PTR_W = $clog2(Depth);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(Depth);
    localparam logic [c_CNT_W-1:0] c_AF    = c_CNT_W'(AlmostFullLevel);
    localparam logic [c_CNT_W-1:0] c_AE    = c_CNT_W'(AlmostEmptyLevel);

    logic [Width-1:0]   r_mem [Depth];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    // A pop frees a slot on the same edge, so a full FIFO can still take a push.
    assign w_push  = cPush && (!w_full || cPop);
    assign w_pop   = cPop && !w_empty;

    assign hFull        = w_full;
    assign hEmpty       = w_empty;
    assign hAlmostFull  = (r_count >= c_AF);
    assign hAlmostEmpty = (r_count <= c_AE);
    assign hCount       = r_count;
    assign hOverflow    = r_overflow;
    assign hUnderflow   = r_underflow;

    always_ff @(posedge clock) begin
        if (reset && w_push) begin
            r_mem[r_wrPtr] <= cData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
            // A new error in the same cycle wins over the clear request.
            if (cPush && w_full && !cPop) begin
                r_overflow <= 1'b1;
            end else if (cClearErr) begin
                r_overflow <= 1'b0;
            end
            if (cPop && w_empty) begin
                r_underflow <= 1'b1;
            end else if (cClearErr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (ShowAhead != 0) begin : g_show_ahead
            assign hData = r_mem[r_rdPtr];
        end else begin : g_registered
            logic [Width-1:0] r_data;
            always_ff @(posedge clock) begin
                if (!reset) begin
                    r_data <= '0;
                end else if (w_pop) begin
                    r_data <= r_mem[r_rdPtr];
                end
            end
            assign hData = r_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================================
//  Module   : tb_param_fifo
//  Purpose  : Self-checking bench for param_fifo, registered and show-ahead
//             instances driven in parallel against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_fifo;

    localparam int c_DEPTH = 8;
    localparam int c_AF    = 6;
    localparam int c_AE    = 2;

    logic       clock;
    logic       reset;
    logic [7:0] cData;
    logic       cPush;
    logic       cPop;
    logic       cClearErr;

    logic [7:0] hData;
    logic       hFull, hEmpty, hAlmostFull, hAlmostEmpty, hOverflow, hUnderflow;
    logic [3:0] hCount;

    logic [7:0] saData;
    logic       saFull, saEmpty, saAlmostFull, saAlmostEmpty, saOverflow, saUnderflow;
    logic [3:0] saCount;

    int total = 0;
    int bad   = 0;

    logic [7:0] mQ [$];
    logic       mOv;
    logic       mUn;
    logic [7:0] mData;

    param_fifo #(.Width(8), .Depth(c_DEPTH), .AlmostFullLevel(c_AF),
                 .AlmostEmptyLevel(c_AE), .ShowAhead(0)) u_reg (
        .clock(clock), .reset(reset), .cData(cData), .cPush(cPush), .cPop(cPop),
        .cClearErr(cClearErr), .hData(hData), .hFull(hFull), .hEmpty(hEmpty),
        .hAlmostFull(hAlmostFull), .hAlmostEmpty(hAlmostEmpty), .hCount(hCount),
        .hOverflow(hOverflow), .hUnderflow(hUnderflow)
    );

    param_fifo #(.Width(8), .Depth(c_DEPTH), .AlmostFullLevel(c_AF),
                 .AlmostEmptyLevel(c_AE), .ShowAhead(1)) u_sa (
        .clock(clock), .reset(reset), .cData(cData), .cPush(cPush), .cPop(cPop),
        .cClearErr(cClearErr), .hData(saData), .hFull(saFull), .hEmpty(saEmpty),
        .hAlmostFull(saAlmostFull), .hAlmostEmpty(saAlmostEmpty), .hCount(saCount),
        .hOverflow(saOverflow), .hUnderflow(saUnderflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll();
        int n;
        n = mQ.size();
        check("count",   32'(hCount), 32'(n));
        check("full",    32'(hFull), 32'(n == c_DEPTH));
        check("empty",   32'(hEmpty), 32'(n == 0));
        check("afull",   32'(hAlmostFull), 32'(n >= c_AF));
        check("aempty",  32'(hAlmostEmpty), 32'(n <= c_AE));
        check("ovf",     32'(hOverflow), 32'(mOv));
        check("unf",     32'(hUnderflow), 32'(mUn));
        check("data",    32'(hData), 32'(mData));
        check("sa_count", 32'(saCount), 32'(n));
        check("sa_flags", {26'd0, saFull, saEmpty, saAlmostFull, saAlmostEmpty, saOverflow, saUnderflow},
              {26'd0, n == c_DEPTH, n == 0, n >= c_AF, n <= c_AE, mOv, mUn});
        if (n != 0) begin
            check("sa_data", 32'(saData), 32'(mQ[0]));
        end
    endtask

    // Drive at the falling edge, update the model from the rules, compare after the rising edge.
    task automatic step(input logic p, input logic o, input logic [7:0] d,
                        input logic clr, input logic rst);
        bit full, empty, pushOk, popOk;
        cPush = p; cPop = o; cData = d; cClearErr = clr; reset = rst;
        @(posedge clock);
        if (!rst) begin
            mQ.delete();
            mOv = 1'b0; mUn = 1'b0; mData = 8'h00;
        end else begin
            full   = (mQ.size() == c_DEPTH);
            empty  = (mQ.size() == 0);
            pushOk = p && (!full || o);
            popOk  = o && !empty;
            if (popOk) mData = mQ.pop_front();
            if (pushOk) mQ.push_back(d);
            if (p && full && !o) mOv = 1'b1; else if (clr) mOv = 1'b0;
            if (o && empty) mUn = 1'b1; else if (clr) mUn = 1'b0;
        end
        #1;
        checkAll();
        @(negedge clock);
    endtask

    initial begin
        mOv = 1'b0; mUn = 1'b0; mData = 8'h00;
        reset = 1'b0; cPush = 1'b0; cPop = 1'b0; cData = 8'h00; cClearErr = 1'b0;
        @(negedge clock);
        step(1, 1, 8'h99, 0, 0);
        step(0, 0, 8'h00, 0, 0);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, 1);
        step(1, 0, 8'hFF, 0, 1);
        check("ovf_after_9th", 32'(hOverflow), 32'd1);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 1);
        check("last_drained", 32'(hData), 32'h08);

        // Push+pop while empty
        step(0, 0, 8'h00, 1, 1);
        step(1, 1, 8'hA5, 0, 1);
        check("pp_empty_unf", 32'(hUnderflow), 32'd1);
        step(0, 1, 8'h00, 0, 1);
        check("pp_empty_data", 32'(hData), 32'hA5);

        // Push+pop while full
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h10 + i), 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 8'h55, 0, 1);
        check("full_pp_count", 32'(hCount), 32'd8);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 1);
        check("full_pp_tail", 32'(hData), 32'h55);

        // Interleaved traffic across the pointer wrap
        for (int i = 0; i < 20; i++) step(1'(i % 3 != 2), 1'(i % 2), 8'(8'h80 + i), 0, 1);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0, 1);

        // Show-ahead latency into an empty FIFO
        step(0, 0, 8'h00, 1, 1);
        step(1, 0, 8'h3C, 0, 1);
        check("sa_fwft", 32'(saData), 32'h3C);
        step(0, 0, 8'h00, 0, 1);
        check("sa_hold", 32'(saData), 32'h3C);

        // Mid-operation reset and clear-versus-error priority
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i), 0, 1);
        step(1, 0, 8'hEE, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 1);
        step(1, 1, 8'h77, 0, 0);
        check("rst_count", 32'(hCount), 32'd0);
        step(0, 1, 8'h00, 1, 1);
        check("clr_vs_unf", 32'(hUnderflow), 32'd1);
        step(0, 0, 8'h00, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
                 8'($urandom), 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) >= 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter Width, default 8, data word width in bits, Width >= 1.
REQ-002 Parameter Depth, default 8, entry count, power of 2, Depth >= 2.
REQ-003 Parameter AlmostFullLevel, default Depth-2, count at or above which hAlmostFull asserts, range 1..Depth.
REQ-004 Parameter AlmostEmptyLevel, default 2, count at or below which hAlmostEmpty asserts, range 0..Depth-1.
REQ-005 Parameter ShowAhead, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-006 clock  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset, sampled on rising clock edge.
REQ-008 cData  input  Width  write data.
REQ-009 cPush  input  1  write request.
REQ-010 cPop  input  1  read request.
REQ-011 cClearErr  input  1  clears sticky error flags.
REQ-012 hData  output  Width  read data.
REQ-013 hFull  output  1  count == Depth.
REQ-014 hEmpty  output  1  count == 0.
REQ-015 hAlmostFull  output  1  count >= AlmostFullLevel.
REQ-016 hAlmostEmpty  output  1  count <= AlmostEmptyLevel.
REQ-017 hCount  output  $clog2(Depth)+1  current occupancy.
REQ-018 hOverflow  output  1  sticky: push rejected.
REQ-019 hUnderflow  output  1  sticky: pop rejected.

Function
REQ-020 Storage SHALL be Depth x Width; read/write pointers $clog2(Depth) bits, wrap modulo Depth with no extra logic.
REQ-021 Occupancy SHALL be held in an explicit counter; hFull, hEmpty, hAlmostFull, hAlmostEmpty SHALL be combinational decodes of hCount only.
REQ-022 Push accepted iff cPush && (!hFull || cPop) -- word written at write pointer, pointer +1.
REQ-023 Pop accepted iff cPop && !hEmpty -- read pointer +1.
REQ-024 Push+pop both accepted: hCount unchanged; push only: +1; pop only: -1.
REQ-025 Push+pop while empty: push accepted, pop rejected, hUnderflow set, hCount becomes 1.
REQ-026 Push+pop while full: both accepted, oldest word read, new word written into freed slot, hCount stays Depth, no overflow.
REQ-027 Rejected push (cPush && hFull && !cPop) SHALL set hOverflow; storage, pointers, hCount unchanged.
REQ-028 Rejected pop (cPop && hEmpty) SHALL set hUnderflow; hData unchanged.
REQ-029 cClearErr SHALL clear both sticky flags next edge; a same-cycle new error takes priority and leaves the flag set.
REQ-030 ShowAhead=0: on accepted pop, hData SHALL load the word at the read pointer on that edge (1-cycle latency); otherwise hData holds.
REQ-031 ShowAhead=1: hData SHALL combinationally present the word at the read pointer whenever !hEmpty (0 latency); accepted pop advances to next word; value while hEmpty is don't-care but SHALL be the last stored word at that location, never X after first write.
REQ-032 ShowAhead=1: a word pushed into an empty FIFO SHALL appear on hData the cycle after the push edge.
REQ-033 No bypass: a word SHALL never be readable in the same cycle it is pushed.

Reset
REQ-034 While reset == 0 at a rising edge: pointers, hCount, hOverflow, hUnderflow SHALL be 0; hData (ShowAhead=0) SHALL be 0; cPush/cPop ignored.
REQ-035 After reset: hEmpty=1, hAlmostEmpty=1, hFull=0, hAlmostFull=0; storage contents not reset.
REQ-036 Reset asserted mid-operation SHALL discard all contents in one cycle regardless of cPush/cPop.

Verification (Width=8, Depth=8, AlmostFullLevel=6, AlmostEmptyLevel=2)
REQ-037 Push 0x01..0x08 -> hCount 1..8, hAlmostFull at count 6, hFull at 8; 9th push 0xFF -> hOverflow=1, hCount=8; pop x8 -> 0x01..0x08 in order.
REQ-038 Empty FIFO, cPush=1 cPop=1 cData=0xA5 -> hCount=1, hUnderflow=1; pop -> 0xA5 (ShowAhead=0: visible one cycle after pop edge).
REQ-039 Full FIFO, cPush=1 cPop=1 cData=0x55 for 3 cycles -> hCount stays 8, oldest three words out, no overflow; drain tail ends 0x55,0x55,0x55.
REQ-040 20 push/pop cycles interleaved crossing pointer wrap -> output order equals input order, hCount matches model each cycle.
REQ-041 ShowAhead=1: push 0x3C into empty -> next cycle hData=0x3C, hEmpty=0 with no pop issued.
REQ-042 Fill to 5, set hOverflow, assert reset=0 one cycle -> hCount=0, hEmpty=1, hOverflow=0, hData=0; cClearErr with simultaneous rejected pop -> hUnderflow stays 1.
